// File: rtl/float_dot_accumulate.sv
// Multi-lane float dot product into an exact Kulisch (fixed-point) accumulator.
// Optional FLOAT_DOT_ACC_OVERFLOW_DETECT_EN: saturate and flag accumulator overflow.
module float_dot_accumulate #(
   parameter  int EXP_IN        = 3,
   parameter  int FRAC_IN       = 2,
   parameter  int LANES         = 4,
   parameter  int ACC_EXTRA_BIT = 8,
   localparam int W             = 1 + EXP_IN + FRAC_IN,
   localparam int EXP_OUT       = EXP_IN + 1,
   localparam int FRAC_OUT      = 2 * FRAC_IN + 1,
   localparam int ACC_FRAC      = FRAC_OUT + 2**(EXP_OUT-1) - 2,
   localparam int ACC_NON_FRAC  = 1 + 2**(EXP_OUT-1) + ACC_EXTRA_BIT + $clog2(LANES),
   localparam int ACC_TOTAL     = ACC_FRAC + ACC_NON_FRAC
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*W-1:0]     in_a,
   input  logic [LANES*W-1:0]     in_b,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_TOTAL-1:0]   out_acc,
   output logic                   out_nan,
   output logic                   out_overflow
);

   localparam int MW = FRAC_IN + 1;
   localparam int PW = 2 * MW;
   localparam int SW = EXP_IN + 2;
   localparam int P  = 2**$clog2(LANES);

   logic [ACC_TOTAL-1:0] prod [LANES];
   logic [LANES-1:0]     nan_lane;

   // Product shift works out to ea+eb+1 for this accumulator layout, so it is never negative.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [W-1:0]         a, b;
      logic [EXP_IN-1:0]    ea, eb, ea_eff, eb_eff;
      logic [MW-1:0]        ma, mb;
      logic [PW-1:0]        mp;
      logic [SW-1:0]        sh;
      logic [ACC_TOTAL-1:0] mag;
      logic                 special;

      assign a       = in_a[g*W +: W];
      assign b       = in_b[g*W +: W];
      assign ea      = a[W-2 -: EXP_IN];
      assign eb      = b[W-2 -: EXP_IN];
      assign ea_eff  = (ea == '0) ? EXP_IN'(1) : ea;
      assign eb_eff  = (eb == '0) ? EXP_IN'(1) : eb;
      assign ma      = {|ea, a[FRAC_IN-1:0]};
      assign mb      = {|eb, b[FRAC_IN-1:0]};
      assign mp      = PW'(ma) * PW'(mb);
      assign sh      = SW'(ea_eff) + SW'(eb_eff) + SW'(1);
      assign mag     = ACC_TOTAL'(mp) << sh;
      assign special = (&ea) | (&eb);
      assign nan_lane[g] = special;
      assign prod[g]     = special ? '0 : ((a[W-1] ^ b[W-1]) ? -mag : mag);
   end

   logic [ACC_TOTAL-1:0] s1_prod_q [LANES];
   logic                 s1_valid_q, s1_last_q, s1_nan_q;
   logic [ACC_TOTAL-1:0] s2_sum_q;
   logic                 s2_valid_q, s2_last_q, s2_nan_q;
   logic [ACC_TOTAL-1:0] acc_q, acc_d;
   logic                 first_q;
   logic                 nan_q, nan_d;
   logic                 out_valid_q, out_nan_q;
   logic [ACC_TOTAL-1:0] out_acc_q;
   logic [ACC_TOTAL-1:0] node [P];
   logic [ACC_TOTAL-1:0] tree_sum;
   logic [ACC_TOTAL-1:0] add_raw;
   logic                 stall;

   always_comb begin
      for (int i = 0; i < P; i++) node[i] = (i < LANES) ? s1_prod_q[i] : '0;
      for (int s = P / 2; s >= 1; s = s / 2) begin
         for (int i = 0; i < s; i++) node[i] = node[2*i] + node[2*i+1];
      end
      tree_sum = node[0];
   end

   assign stall    = out_valid_q && !out_ready && s2_valid_q && s2_last_q;
   assign in_ready = !stall;
   assign add_raw  = acc_q + s2_sum_q;
   assign nan_d    = nan_q | s2_nan_q;

`ifdef FLOAT_DOT_ACC_OVERFLOW_DETECT_EN
   logic                 ovf_q, ovf_d, ovf_now, out_ovf_q;
   logic [ACC_TOTAL-1:0] sat_val;

   assign ovf_now = !first_q && (acc_q[ACC_TOTAL-1] == s2_sum_q[ACC_TOTAL-1])
                    && (add_raw[ACC_TOTAL-1] != acc_q[ACC_TOTAL-1]);
   assign sat_val = acc_q[ACC_TOTAL-1] ? {1'b1, {(ACC_TOTAL-1){1'b0}}}
                                       : {1'b0, {(ACC_TOTAL-1){1'b1}}};
   assign acc_d   = first_q ? s2_sum_q : (ovf_now ? sat_val : add_raw);
   assign ovf_d   = ovf_q | ovf_now;
   assign out_overflow = out_ovf_q;
`else
   assign acc_d   = first_q ? s2_sum_q : add_raw;
   assign out_overflow = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_nan_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_nan_q    <= 1'b0;
         s2_sum_q    <= '0;
         acc_q       <= '0;
         first_q     <= 1'b1;
         nan_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_nan_q   <= 1'b0;
`ifdef FLOAT_DOT_ACC_OVERFLOW_DETECT_EN
         ovf_q       <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               for (int i = 0; i < LANES; i++) s1_prod_q[i] <= prod[i];
               s1_last_q <= in_last;
               s1_nan_q  <= |nan_lane;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_sum_q  <= tree_sum;
               s2_last_q <= s1_last_q;
               s2_nan_q  <= s1_nan_q;
            end
            if (s2_valid_q) begin
               if (s2_last_q) begin
                  // Hand the finished vector to the output and rearm for the next one.
                  out_valid_q <= 1'b1;
                  out_acc_q   <= acc_d;
                  out_nan_q   <= nan_d;
                  acc_q       <= '0;
                  first_q     <= 1'b1;
                  nan_q       <= 1'b0;
`ifdef FLOAT_DOT_ACC_OVERFLOW_DETECT_EN
                  out_ovf_q   <= ovf_d;
                  ovf_q       <= 1'b0;
`endif
               end else begin
                  acc_q   <= acc_d;
                  first_q <= 1'b0;
                  nan_q   <= nan_d;
`ifdef FLOAT_DOT_ACC_OVERFLOW_DETECT_EN
                  ovf_q   <= ovf_d;
`endif
               end
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_acc   = out_acc_q;
   assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_float_dot_accumulate.sv
// Directed self-checking bench for float_dot_accumulate at default lane/format settings.
module tb_float_dot_accumulate;
`ifdef FLOAT_DOT_ACC_OVERFLOW_DETECT_EN
   localparam int XB = 0;
`else
   localparam int XB = 8;
`endif
   localparam int LANES = 4;
   localparam int W     = 6;
   localparam int LW    = LANES * W;
   localparam int AT    = 11 + (1 + 8 + XB + 2);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [LW-1:0] in_a = '0;
   logic [LW-1:0] in_b = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AT-1:0] out_acc;
   logic          out_nan;
   logic          out_overflow;

   float_dot_accumulate #(.EXP_IN(3), .FRAC_IN(2), .LANES(LANES), .ACC_EXTRA_BIT(XB)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_nan(out_nan), .out_overflow(out_overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AT-1:0] acc;
      logic          nan;
      logic          ovf;
      int            cyc;
   } res_t;

   res_t q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clock) cyc++;

   always @(negedge clock)
      if (out_valid && out_ready)
         q.push_back('{acc: out_acc, nan: out_nan, ovf: out_overflow, cyc: cyc});

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [LW-1:0] rep(input logic [W-1:0] v);
      return {LANES{v}};
   endfunction

   // Caller is aligned just after a rising edge; returns aligned the same way.
   task automatic send_beat(input logic [LW-1:0] a, input logic [LW-1:0] b,
                            input logic last, output int acc_cyc);
      logic got;
      got = 1'b0;
      acc_cyc = -1;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      for (int n = 0; n < 60; n++) begin
         #2;
         got = in_ready;
         acc_cyc = cyc;
         @(posedge clock); #1;
         if (got) break;
      end
      if (!got) begin
         errors++; checks++;
         $display("FAIL send_beat timeout: in_ready=0 required 1");
      end
   endtask

   task automatic wait_results(input int n);
      int k;
      for (k = 0; k < 200; k++) begin
         if (q.size() >= n) break;
         @(negedge clock);
      end
      if (q.size() < n) begin
         errors++; checks++;
         $display("FAIL wait_results timeout: got=%0d required=%0d", q.size(), n);
      end
   endtask

   task automatic pop(output res_t r);
      if (q.size() > 0) r = q.pop_front();
      else r = '{acc: '0, nan: 1'b0, ovf: 1'b0, cyc: 0};
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got=%b required=0", out_valid); end
      checks++; if (out_acc !== '0) begin errors++; $display("FAIL reset_out_acc: got=%0d required=0", out_acc); end
      checks++; if (out_nan !== 1'b0) begin errors++; $display("FAIL reset_out_nan: got=%b required=0", out_nan); end
      checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_overflow: got=%b required=0", out_overflow); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%b required=1", in_ready); end
   endtask

   task automatic test_single_beat();
      int t; res_t r;
      send_beat(rep(6'h0C), rep(6'h0C), 1'b1, t);
      in_valid = 1'b0;
      wait_results(1); pop(r);
      checks++; if (r.acc !== AT'(8192)) begin errors++; $display("FAIL single_acc: got=%0d required=8192", r.acc); end
      checks++; if (r.nan !== 1'b0) begin errors++; $display("FAIL single_nan: got=%b required=0", r.nan); end
      checks++; if (r.cyc - t !== 3) begin errors++; $display("FAIL single_latency: got=%0d required=3", r.cyc - t); end
   endtask

   task automatic test_two_beat();
      int t; res_t r;
      send_beat(rep(6'h10), rep(6'h0E), 1'b0, t);
      send_beat(rep(6'h10), rep(6'h0E), 1'b1, t);
      in_valid = 1'b0;
      wait_results(1); pop(r);
      checks++; if (r.acc !== AT'(49152)) begin errors++; $display("FAIL two_beat_acc: got=%0d required=49152", r.acc); end
   endtask

   task automatic test_mixed_signs();
      int t; res_t r;
      // lanes: denormal*1.0, -1.0*-1.5, -0*1.0, 2.0*-1.0
      send_beat({6'h10, 6'h20, 6'h2C, 6'h01}, {6'h2C, 6'h0C, 6'h2E, 6'h0C}, 1'b1, t);
      in_valid = 1'b0;
      wait_results(1); pop(r);
      checks++; if (r.acc !== AT'(-896)) begin errors++; $display("FAIL mixed_acc: got=%0d required=%0d", $signed(r.acc), -896); end
   endtask

   task automatic test_back_to_back();
      int ta, tb; res_t ra, rb;
      send_beat({6'h0C, 6'h0C, 6'h2C, 6'h2C}, rep(6'h0C), 1'b1, ta);
      send_beat(rep(6'h0C), rep(6'h0C), 1'b1, tb);
      in_valid = 1'b0;
      wait_results(2); pop(ra); pop(rb);
      checks++; if (tb - ta !== 1) begin errors++; $display("FAIL b2b_no_bubble: gap=%0d required=1", tb - ta); end
      checks++; if (ra.acc !== AT'(0)) begin errors++; $display("FAIL b2b_a_acc: got=%0d required=0", ra.acc); end
      checks++; if (rb.acc !== AT'(8192)) begin errors++; $display("FAIL b2b_b_acc: got=%0d required=8192", rb.acc); end
   endtask

   task automatic test_nan();
      int t; res_t rn, rc;
      send_beat({6'h0C, 6'h1C, 6'h0C, 6'h0C}, rep(6'h0C), 1'b1, t);
      send_beat(rep(6'h0C), rep(6'h0C), 1'b1, t);
      in_valid = 1'b0;
      wait_results(2); pop(rn); pop(rc);
      checks++; if (rn.acc !== AT'(6144)) begin errors++; $display("FAIL nan_acc: got=%0d required=6144", rn.acc); end
      checks++; if (rn.nan !== 1'b1) begin errors++; $display("FAIL nan_flag: got=%b required=1", rn.nan); end
      checks++; if (rc.nan !== 1'b0) begin errors++; $display("FAIL nan_clean_flag: got=%b required=0", rc.nan); end
      checks++; if (rc.acc !== AT'(8192)) begin errors++; $display("FAIL nan_clean_acc: got=%0d required=8192", rc.acc); end
   endtask

   task automatic test_stall();
      res_t r;
      logic saw_low;
      logic [AT-1:0] exp_v [4];
      exp_v[0] = AT'(8192); exp_v[1] = AT'(73728); exp_v[2] = AT'(-8192); exp_v[3] = AT'(8192);
      saw_low = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            int t;
            send_beat(rep(6'h0C), rep(6'h0C), 1'b1, t);
            send_beat(rep(6'h10), rep(6'h0E), 1'b0, t);
            send_beat(rep(6'h10), rep(6'h0E), 1'b0, t);
            send_beat(rep(6'h10), rep(6'h0E), 1'b1, t);
            send_beat(rep(6'h2C), rep(6'h0C), 1'b1, t);
            send_beat(rep(6'h0C), rep(6'h0C), 1'b1, t);
            in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 40; k++) begin
               @(negedge clock);
               if (out_valid) break;
            end
            for (int k = 0; k < 5; k++) begin
               @(negedge clock);
               if (!in_ready) saw_low = 1'b1;
               checks++;
               if (out_valid !== 1'b1 || out_acc !== AT'(8192)) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%b acc=%0d required valid=1 acc=8192", out_valid, out_acc);
               end
            end
            checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL stall_in_ready: low_seen=%b required=1", saw_low); end
            @(posedge clock); #1 out_ready = 1'b1;
         end
      join
      wait_results(4);
      for (int k = 0; k < 4; k++) begin
         pop(r);
         checks++;
         if (r.acc !== exp_v[k]) begin
            errors++;
            $display("FAIL stall_result%0d: got=%0d required=%0d", k, $signed(r.acc), $signed(exp_v[k]));
         end
      end
   endtask

   task automatic test_reset_mid();
      int t; res_t r;
      send_beat(rep(6'h10), rep(6'h0E), 1'b0, t);
      send_beat(rep(6'h10), rep(6'h0E), 1'b0, t);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      send_beat(rep(6'h0C), rep(6'h0C), 1'b1, t);
      in_valid = 1'b0;
      wait_results(1); pop(r);
      checks++; if (r.acc !== AT'(8192)) begin errors++; $display("FAIL reset_mid_acc: got=%0d required=8192", r.acc); end
      repeat (6) @(negedge clock);
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL reset_mid_extra: got=%0d results required=0", q.size()); end
      @(posedge clock); #1;
   endtask

   task automatic test_large();
      int t; res_t r, rc;
      logic [AT-1:0] exp_acc;
      logic          exp_ovf;
`ifdef FLOAT_DOT_ACC_OVERFLOW_DETECT_EN
      exp_acc = AT'(2097151); exp_ovf = 1'b1;
`else
      exp_acc = AT'(2097152); exp_ovf = 1'b0;
`endif
      for (int k = 0; k < 4; k++) send_beat(rep(6'h18), rep(6'h18), (k == 3), t);
      send_beat(rep(6'h0C), rep(6'h0C), 1'b1, t);
      in_valid = 1'b0;
      wait_results(2); pop(r); pop(rc);
      checks++; if (r.acc !== exp_acc) begin errors++; $display("FAIL large_acc: got=%0d required=%0d", r.acc, exp_acc); end
      checks++; if (r.ovf !== exp_ovf) begin errors++; $display("FAIL large_ovf: got=%b required=%b", r.ovf, exp_ovf); end
      checks++; if (rc.ovf !== 1'b0 || rc.acc !== AT'(8192)) begin
         errors++; $display("FAIL after_large: acc=%0d ovf=%b required acc=8192 ovf=0", rc.acc, rc.ovf);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_two_beat();
      test_mixed_signs();
      test_back_to_back();
      test_nan();
      test_stall();
      test_reset_mid();
      test_large();
      repeat (3) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/float_dot_accumulate.md
Name: float_dot_accumulate

Overview:
- Parametrised successor to the single-lane float multiply / Kulisch-add path.
- Takes LANES float pairs per beat, multiplies each pair exactly and converts each product to linear fixed-point.
- Sums the lanes in a registered adder tree and accumulates beats into an internal Kulisch register until an end-of-vector marker arrives.
- Emits the exact fixed-point dot product on a valid/ready output; sits between operand streamers and the fixed-to-float normaliser.

Parameters:
- EXP_IN, 3, exponent bits of every input float (bias 2^(EXP_IN-1)-1)
- FRAC_IN, 2, fraction bits of every input float (hidden leading 1)
- LANES, 4, float pairs per beat, >=1
- ACC_EXTRA_BIT, 8, headroom bits above the single-product requirement
- Derived: EXP_OUT=EXP_IN+1; FRAC_OUT=2*FRAC_IN+1; W=1+EXP_IN+FRAC_IN
- Derived: ACC_FRAC=FRAC_OUT+2^(EXP_OUT-1)-2
- Derived: ACC_NON_FRAC=1+2^(EXP_OUT-1)+ACC_EXTRA_BIT+$clog2(LANES)
- Derived: ACC_TOTAL=ACC_FRAC+ACC_NON_FRAC (30 at defaults)

Ports:
- clock, input, 1, sole clock; everything on rising edge
- reset, input, 1, synchronous, active-high
- in_valid, input, 1, beat offered
- in_ready, output, 1, beat accepted when in_valid&&in_ready
- in_a, input, LANES*W, lane i at [i*W +: W], format {sign,exp,frac}
- in_b, input, LANES*W, same packing
- in_last, input, 1, final beat of current vector
- out_valid, output, 1, result available
- out_ready, input, 1, result consumed when out_valid&&out_ready
- out_acc, output, ACC_TOTAL, two's-complement result, binary point at ACC_FRAC
- out_nan, output, 1, any NaN/Inf operand in this vector
- out_overflow, output, 1, accumulator overflow in this vector (see Optional Feature)

Behaviour:
- Clock and reset are fixed: one clock, named clock; reset is synchronous and active-high, named reset.
- Reset clears all stage valids, the accumulator, nan/overflow stickies, out_valid, out_acc=0, out_nan=0 and out_overflow=0. in_ready=1 from the first cycle after reset.
- Reset mid-vector discards all partial state; no result is emitted.
- Operand decode:
  - exp==0: denormal, no hidden bit.
  - exp==all-ones: NaN/Inf; the lane contributes 0 and sets the vector nan sticky.
  - ±0 contributes 0.
- Pipeline, advancing only when not stalled:
  - S1 registers the LANES exact products, each converted to ACC_TOTAL fixed-point (sign-applied).
  - S2 registers the lane sum from a balanced adder tree.
  - S3 (accumulator): acc <= first_beat ? S2sum : acc+S2sum.
- Each stage carries valid and last. After S3 consumes a last beat, the accumulator value, nan and overflow are copied into the output register and out_valid=1. The accumulator, the stickies and first_beat=1 are cleared in the same cycle.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+3.
- Stall = out_valid && !out_ready && S3 holds a last beat. Stall freezes S1-S3; in_ready=!stall.
- out_acc/out_nan/out_overflow hold stable while out_valid && !out_ready.
- Back-to-back vectors are supported: a new vector's first beat may be accepted the cycle after the previous last beat, with no bubble and no cross-contamination.
- A single-beat vector (in_last on the first beat) is legal.
- in_valid=0 cycles inside a vector insert bubbles only; the result is unchanged.

Optional Feature:
- Macro FLOAT_DOT_ACC_OVERFLOW_DETECT_EN.
- Defined: S3 detects signed overflow on acc+S2sum (both operands same sign, result sign differs). On overflow the accumulator saturates to max positive/negative and sets the overflow sticky.
- Undefined: addition wraps modulo 2^ACC_TOTAL, no detection logic is built, and out_overflow is tied 0.

Test Plan:
- Defaults; one beat, all lanes a=0x0C (1.0), b=0x0C, last=1 -> out_acc=8192 (4.0) exactly 3 cycles after acceptance, out_nan=0.
- Two beats, all lanes a=0x10 (2.0), b=0x0E (1.5), last on 2nd -> out_acc=49152 (24.0).
- Vector A = one beat of 1.0×1.0 lanes with lanes 0-1 a=0x2C (-1.0), last; next cycle vector B = one beat of 1.0×1.0, last -> A=0, B=8192; no bubble on in_ready.
- Lane 2 a=0x1C (exp 111) in an otherwise-1.0 vector -> out_acc=6144, out_nan=1. Next clean vector reports out_nan=0.
- Hold out_ready=0 for 5 cycles with 3 further beats queued -> in_ready falls, out_acc stable, no beat lost; releasing yields the correct following result.
- Assert reset for one cycle mid-vector after 2 beats, then send one 1.0×1.0 last beat -> out_acc=8192. With macro on, ACC_EXTRA_BIT=0 and repeated 2^3×2^3 products until positive overflow -> saturated max, out_overflow=1.
